// File: rtl/bist_ctrl.sv
// BIST sequencer: INIT -> RUN -> DRAIN -> CMP -> DONE, driving TPG/MISR and grading the MISR signature.
// Optional BIST_SIG_CAPTURE_EN builds a register that freezes the signature seen in CMP.
module bist_ctrl #(
    parameter int                   NUM_PATTERNS = 15,
    parameter int                   CNT_WIDTH    = 4,
    parameter int                   CUT_LATENCY  = 1,
    parameter int                   SIG_WIDTH    = 4,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 4'b1011
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SIG_WIDTH-1:0] misr_sig,
    output logic                 tpg_load,
    output logic                 tpg_en,
    output logic                 misr_clr,
    output logic                 misr_en,
    output logic                 test_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [CNT_WIDTH-1:0] pattern_cnt,
    output logic [SIG_WIDTH-1:0] captured_sig
);

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, CMP, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_PAT   = CNT_WIDTH'(NUM_PATTERNS - 1);
    localparam logic [2:0]           LAST_DRAIN = 3'((CUT_LATENCY > 0) ? CUT_LATENCY - 1 : 0);

    state_t     state, state_nxt;
    logic [2:0] drain_cnt;
    logic       match;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = RUN;
            RUN:     if (pattern_cnt == LAST_PAT) state_nxt = (CUT_LATENCY == 0) ? CMP : DRAIN;
            DRAIN:   if (drain_cnt == LAST_DRAIN) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    if (start) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
        // Abort only matters while a run is in flight; IDLE/DONE ignore it.
        if (abort && (state == INIT || state == RUN || state == DRAIN || state == CMP))
            state_nxt = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pattern_cnt <= '0;
            drain_cnt   <= '0;
            match       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == INIT || state_nxt == IDLE)
                pattern_cnt <= '0;
            else if (state == RUN)
                pattern_cnt <= pattern_cnt + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            if (state == CMP)
                match <= (misr_sig == GOLDEN_SIG);
        end
    end

    // Moore decode: every output depends on the state register only.
    always_comb begin
        tpg_load  = 1'b0;
        tpg_en    = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        test_mode = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        fail      = 1'b0;
        case (state)
            INIT: begin
                tpg_load  = 1'b1;
                misr_clr  = 1'b1;
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            RUN: begin
                tpg_en    = 1'b1;
                misr_en   = 1'b1;
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            DRAIN: begin
                misr_en   = 1'b1;
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            CMP: begin
                test_mode = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                pass = match;
                fail = ~match;
            end
            default: ;
        endcase
    end

`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_WIDTH-1:0] cap_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cap_q <= '0;
        else if (state_nxt == INIT)
            cap_q <= '0;
        else if (state == CMP && !abort)
            cap_q <= misr_sig;
    end

    assign captured_sig = cap_q;
`else
    assign captured_sig = '0;
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Randomized bench for bist_ctrl: a phase-length model predicts every output cycle by cycle.
module tb_bist_ctrl;

    localparam logic [3:0] GOLD = 4'b1011;
    localparam logic [6:0] F_INIT = 7'b1010110;
    localparam logic [6:0] F_DONE = 7'b0000001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sel   = 1'b0;
    logic [3:0] misr_sig = 4'h0;
    logic       start_a, start_b;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic       tpg_load_a, tpg_en_a, misr_clr_a, misr_en_a, test_mode_a, busy_a, done_a, pass_a, fail_a;
    logic       tpg_load_b, tpg_en_b, misr_clr_b, misr_en_b, test_mode_b, busy_b, done_b, pass_b, fail_b;
    logic [3:0] cnt_a, cnt_b, cap_a, cap_b;

    bist_ctrl dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort), .misr_sig(misr_sig),
        .tpg_load(tpg_load_a), .tpg_en(tpg_en_a), .misr_clr(misr_clr_a), .misr_en(misr_en_a),
        .test_mode(test_mode_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
        .pattern_cnt(cnt_a), .captured_sig(cap_a)
    );

    bist_ctrl #(.NUM_PATTERNS(1), .CUT_LATENCY(0)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort), .misr_sig(misr_sig),
        .tpg_load(tpg_load_b), .tpg_en(tpg_en_b), .misr_clr(misr_clr_b), .misr_en(misr_en_b),
        .test_mode(test_mode_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .pattern_cnt(cnt_b), .captured_sig(cap_b)
    );

    // Flag order: tpg_load, tpg_en, misr_clr, misr_en, test_mode, busy, done
    logic [6:0] fl_a, fl_b, fl;
    logic [3:0] cnt_o, cap_o;
    logic       pass_o, fail_o;
    assign fl_a   = {tpg_load_a, tpg_en_a, misr_clr_a, misr_en_a, test_mode_a, busy_a, done_a};
    assign fl_b   = {tpg_load_b, tpg_en_b, misr_clr_b, misr_en_b, test_mode_b, busy_b, done_b};
    assign fl     = sel ? fl_b : fl_a;
    assign cnt_o  = sel ? cnt_b : cnt_a;
    assign cap_o  = sel ? cap_b : cap_a;
    assign pass_o = sel ? pass_b : pass_a;
    assign fail_o = sel ? fail_b : fail_a;

    // Expected outputs k edges after the start-sampling edge (k=1 is that edge).
    function automatic void model(input int np, input int cl, input int k,
                                  output logic [6:0] f, output logic [6:0] mask, output logic [3:0] cnt);
        int len;
        len  = np + cl + 3;
        mask = 7'h7f;
        if (k == 1) begin
            f = F_INIT; cnt = 4'd0;
        end else if (k <= 1 + np) begin
            f = 7'b0101110; cnt = 4'(k - 2);
        end else if (k <= 1 + np + cl) begin
            f = 7'b0001110; cnt = 4'(np);
        end else if (k == len - 1) begin
            f = 7'b0000010; mask = 7'b1111011; cnt = 4'(np);
        end else begin
            f = F_DONE; cnt = 4'(np);
        end
    endfunction

    function automatic logic [3:0] exp_capture(input logic [3:0] sig);
`ifdef BIST_SIG_CAPTURE_EN
        return sig;
`else
        return 4'h0;
`endif
    endfunction

    task automatic run_once(input bit s, input logic [3:0] cmp_sig, input bit hold);
        int np, cl, len;
        int tpg_n = 0, misr_n = 0, done_k = 0, bad_k = 0;
        logic [6:0] ef, em, bad_obs, bad_exp;
        logic [3:0] ec;
        logic ep, efl, m;
        np  = s ? 1 : 15;
        cl  = s ? 0 : 1;
        len = np + cl + 3;
        m   = (cmp_sig == GOLD);
        bad_obs = '0;
        bad_exp = '0;
        @(negedge clock);
        sel = s; start = 1'b1; misr_sig = 4'($urandom);
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            model(np, cl, k, ef, em, ec);
            ep  = (k == len) & m;
            efl = (k == len) & ~m;
            if ((((fl ^ ef) & em) !== 7'h0 || cnt_o !== ec || pass_o !== ep || fail_o !== efl) && bad_k == 0) begin
                bad_k = k; bad_obs = fl; bad_exp = ef;
            end
            tpg_n  += int'(fl[5]);
            misr_n += int'(fl[3]);
            if (fl[0] && done_k == 0) done_k = k;
            misr_sig = (k == len - 1) ? cmp_sig : 4'($urandom);
        end
        tests++;
        if (bad_k != 0) begin
            fails++;
            $display("FAIL trace dut%0d: cycle %0d flags got %b expected %b", s, bad_k, bad_obs, bad_exp);
        end
        tests++;
        if (done_k != len) begin
            fails++;
            $display("FAIL latency dut%0d: done at cycle %0d expected %0d", s, done_k, len);
        end
        tests++;
        if (tpg_n != np) begin
            fails++;
            $display("FAIL tpg_en_count dut%0d: got %0d expected %0d", s, tpg_n, np);
        end
        tests++;
        if (misr_n != np + cl) begin
            fails++;
            $display("FAIL misr_en_count dut%0d: got %0d expected %0d", s, misr_n, np + cl);
        end
        tests++;
        if (pass_o !== m || fail_o !== ~m) begin
            fails++;
            $display("FAIL verdict dut%0d sig %h: pass/fail got %b%b expected %b%b", s, cmp_sig, pass_o, fail_o, m, ~m);
        end
        tests++;
        if (cap_o !== exp_capture(cmp_sig)) begin
            fails++;
            $display("FAIL captured_sig dut%0d: got %h expected %h", s, cap_o, exp_capture(cmp_sig));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if (fl_a !== 7'h0 || fl_b !== 7'h0 || {pass_a, fail_a, pass_b, fail_b} !== 4'h0) begin
            fails++;
            $display("FAIL reset_flags: got %b/%b expected 0", fl_a, fl_b);
        end
        tests++;
        if ({cnt_a, cnt_b, cap_a, cap_b} !== 16'h0) begin
            fails++;
            $display("FAIL reset_regs: got %h expected 0", {cnt_a, cnt_b, cap_a, cap_b});
        end
        reset = 1'b0;
        abort = 1'b1;
        repeat (3) @(negedge clock);
        abort = 1'b0;
        tests++;
        if (fl_a !== 7'h0) begin
            fails++;
            $display("FAIL idle_abort: flags got %b expected 0", fl_a);
        end
    endtask

    task automatic test_pass_fail();
        logic [3:0] sig;
        run_once(0, GOLD, 0);
        run_once(0, 4'b1010, 0);
        for (int i = 0; i < 6; i++) begin
            sig = ($urandom_range(1) == 1) ? GOLD : 4'($urandom);
            run_once(0, sig, 0);
        end
    endtask

    task automatic test_min_config();
        logic [3:0] sig;
        for (int i = 0; i < 4; i++) begin
            sig = (i % 2 == 0) ? GOLD : 4'($urandom);
            run_once(1, sig, 0);
        end
        sel = 1'b0;
    endtask

    task automatic test_abort();
        bit found = 0;
        int n = 0;
        @(negedge clock);
        sel = 1'b0; start = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (tpg_en_a && cnt_a == 4'd7) found = 1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_reach: pattern_cnt 7 not seen, got %0d", cnt_a);
        end else begin
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            tests++;
            if (fl_a !== 7'h0 || cnt_a !== 4'd0 || {pass_a, fail_a} !== 2'b00 || cap_a !== 4'h0) begin
                fails++;
                $display("FAIL abort_idle: flags %b cnt %0d cap %h expected all 0", fl_a, cnt_a, cap_a);
            end
            repeat (20) begin
                @(negedge clock);
                n += int'(tpg_en_a);
            end
            tests++;
            if (n != 0) begin
                fails++;
                $display("FAIL abort_tpg: tpg_en cycles after abort got %0d expected 0", n);
            end
        end
    endtask

    task automatic test_reset_drain();
        @(negedge clock);
        sel = 1'b0; start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        tests++;
        if (fl_a !== 7'b0001110) begin
            fails++;
            $display("FAIL drain_state: flags got %b expected 0001110", fl_a);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (fl_a !== 7'h0 || cnt_a !== 4'd0 || cap_a !== 4'h0 || {pass_a, fail_a} !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: flags %b cnt %0d cap %h expected all 0", fl_a, cnt_a, cap_a);
        end
        @(negedge clock);
        reset = 1'b0;
        run_once(0, 4'($urandom), 0);
    endtask

    task automatic wait_done(input string name);
        int done_k = 0;
        for (int k = 2; k <= 30 && done_k == 0; k++) begin
            @(negedge clock);
            if (done_a) done_k = k;
        end
        tests++;
        if (done_k != 19) begin
            fails++;
            $display("FAIL %s: done at cycle %0d expected 19", name, done_k);
        end
    endtask

    task automatic test_back_to_back();
        run_once(0, GOLD, 1);
        @(negedge clock);
        tests++;
        if (fl_a !== F_INIT || {pass_a, fail_a} !== 2'b00 || cnt_a !== 4'd0) begin
            fails++;
            $display("FAIL b2b_init: flags %b pass/fail %b%b cnt %0d expected %b 00 0", fl_a, pass_a, fail_a, cnt_a, F_INIT);
        end
        start = 1'b0;
        misr_sig = 4'b0110;
        wait_done("b2b_latency");
        tests++;
        if ({pass_a, fail_a} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_verdict: pass/fail got %b%b expected 01", pass_a, fail_a);
        end
        abort = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (fl_a !== F_DONE || fail_a !== 1'b1) begin
            fails++;
            $display("FAIL done_abort: flags %b fail %b expected %b 1", fl_a, fail_a, F_DONE);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        tests++;
        if (fl_a !== F_INIT) begin
            fails++;
            $display("FAIL start_over_abort: flags got %b expected %b", fl_a, F_INIT);
        end
        misr_sig = GOLD;
        wait_done("rerun_latency");
        tests++;
        if ({pass_a, fail_a} !== 2'b10) begin
            fails++;
            $display("FAIL rerun_verdict: pass/fail got %b%b expected 10", pass_a, fail_a);
        end
    endtask

    initial begin
        test_reset();
        test_pass_fail();
        test_min_config();
        test_abort();
        test_reset_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Sequencer for the built-in self-test path: drives the test-pattern generator (TPG), switches the circuit under test (CUT) into test mode, and enables the 4-bit MISR for a fixed pattern count. It then compares the MISR signature against a golden value and reports pass/fail. It sits between the system test-access logic (start/abort) and the TPG/CUT/MISR datapath.

## Interface
- NUM_PATTERNS, 15: patterns applied per run; legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 4: pattern counter width.
- CUT_LATENCY, 1: CUT pipeline depth in cycles, 0..7; drives the drain phase.
- SIG_WIDTH, 4: MISR signature width.
- GOLDEN_SIG, 4'b1011: expected signature.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request; level, sampled in IDLE and DONE only.
- abort  in  1  terminate the run; highest priority after reset.
- misr_sig  in  SIG_WIDTH  current MISR output.
- tpg_load  out  1  one-cycle seed load to the TPG.
- tpg_en  out  1  TPG advance enable.
- misr_clr  out  1  one-cycle synchronous MISR clear.
- misr_en  out  1  MISR capture enable.
- test_mode  out  1  CUT input mux selects TPG.
- busy  out  1  run in progress.
- done  out  1  result valid.
- pass  out  1  signature matched; valid with done.
- fail  out  1  signature mismatched; valid with done.
- pattern_cnt  out  CNT_WIDTH  patterns applied so far.
- captured_sig  out  SIG_WIDTH  frozen signature (see Configuration).

## Operation
- States: IDLE, INIT, RUN, DRAIN, CMP, DONE.
- IDLE:
  - All outputs are 0.
  - start=1 moves to INIT.
- INIT (1 cycle):
  - tpg_load=1, misr_clr=1, test_mode=1, busy=1.
  - pattern_cnt cleared to 0.
  - Always moves to RUN.
- RUN:
  - tpg_en=1, misr_en=1, test_mode=1, busy=1.
  - pattern_cnt increments every cycle.
  - When pattern_cnt reaches NUM_PATTERNS-1 (last pattern cycle), moves to DRAIN. If CUT_LATENCY=0, moves to CMP instead.
- DRAIN:
  - tpg_en=0; misr_en=1, test_mode=1, busy=1.
  - An internal drain counter runs for exactly CUT_LATENCY cycles, then moves to CMP.
- CMP (1 cycle):
  - misr_en=0, busy=1.
  - Registers match = (misr_sig == GOLDEN_SIG).
  - Moves to DONE.
- DONE:
  - done=1, with pass=match and fail=!match; pass and fail are mutually exclusive.
  - busy=0, test_mode=0.
  - pattern_cnt holds NUM_PATTERNS.
  - Results hold until start rises again; a new start moves to INIT and clears done/pass/fail in that same cycle.
- abort=1 in INIT/RUN/DRAIN/CMP:
  - Next state is IDLE; done/pass/fail stay 0; pattern_cnt clears.
  - abort in IDLE or DONE is ignored.
- abort and start both high in DONE: start wins, since abort is ignored there.
- start held high across DONE: immediate rerun. Start is level-sensitive by design.
- All outputs are registered except where noted in Timing.

## Timing
- Reset: state=IDLE; every output is 0, including pattern_cnt and captured_sig.
- Reset mid-run: immediate return to IDLE. The MISR is cleared only by the next INIT.
- Start-to-done latency: 1 (INIT) + NUM_PATTERNS + CUT_LATENCY + 1 (CMP) + 1 cycles. With defaults: 19 cycles from the first clock edge sampling start=1 to done=1.
- tpg_en is high for exactly NUM_PATTERNS cycles.
- misr_en is high for exactly NUM_PATTERNS+CUT_LATENCY cycles.
- misr_sig is sampled at the CMP edge, i.e. after the MISR's final capture has settled.
- Outputs are decoded from state registers (Moore); no combinational input-to-output paths.

## Configuration
- BIST_SIG_CAPTURE_EN defined:
  - captured_sig loads misr_sig in CMP.
  - It holds through DONE and IDLE, and clears only on reset or INIT.
- BIST_SIG_CAPTURE_EN undefined:
  - captured_sig is tied to 0 and no capture register is built.
  - pass/fail behaviour is unchanged.

## Test plan
- Defaults, misr_sig model forced to 4'b1011 at CMP, start pulse:
  - done=1 at cycle 19; pass=1, fail=0.
  - tpg_en high 15 cycles; misr_en high 16 cycles.
- Same run with misr_sig=4'b1010:
  - fail=1, pass=0.
  - captured_sig=4'b1010 with macro; captured_sig=0 without.
- abort asserted in RUN at pattern_cnt=7:
  - Next cycle IDLE; busy=0, done=0, pattern_cnt=0.
  - No further tpg_en.
- CUT_LATENCY=0, NUM_PATTERNS=1:
  - INIT, RUN (1 cycle), CMP, DONE.
  - done 4 cycles after start; misr_en high 1 cycle.
- reset asserted during DRAIN:
  - All outputs 0 asynchronously, before the next edge.
  - A later start runs a full 19-cycle sequence with misr_clr pulsed.
- start held high through DONE:
  - DONE lasts 1 cycle, then INIT; tpg_load and misr_clr pulse again.
  - done drops in INIT.
